// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter slice.
// Contents: FSM state encoding (2-bit), data-width constant, default bank
// geometry, and an index-width helper used by the arbiter and top.
package regbank_arbiter_pkg;

  localparam int DW_C      = 16;
  localparam int NREGS_DEF = 8;
  localparam int AW_DEF    = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Width needed to hold an index 0..n-1 (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector
//   ptr   - index of the last winner; search starts at ptr+1 (mod NREQ)
//   grant - one-hot grant (all zero when no request)
//   idx   - binary index of the winner
//   found - at least one request present
module rr_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            found
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // k = NREQ wraps back to ptr itself, so the previous winner is served
    // only when nobody else is asking.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin front end that shares a bank of load-enabled registers
// between NREQ requesters, one read or write transaction at a time.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/we/addr/wdata  - per-requester request (packed fields)
//   req_ready                - one-hot accept pulse (combinational in IDLE)
//   rsp_valid/rdata/err      - one-hot response pulse with shared data/error
//   bank_ld, bank_d          - one-hot load enables and write data to bank
//   bank_q                   - packed register outputs from the bank
//
// state   | meaning
// IDLE    | waiting; grant is offered combinationally, handshake on the edge
// EXEC    | bank access: pulse bank_ld for writes, capture bank_q for reads
// RESP    | one-cycle response pulse to the original requester
module regbank_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NREGS-1:0]   bank_ld,
  output logic [DW-1:0]      bank_d,
  input  logic [NREGS*DW-1:0] bank_q
);

  localparam int IW = idx_w(NREQ);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cur_w;
  logic            cur_we;
  logic            cur_err;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [DW-1:0]   cur_rdata;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [NREGS-1:0] addr_hot;
  logic [DW-1:0]   q_sel;
  logic [NREQ-1:0] w_hot;
  logic            in_exec_wr;
  logic            in_resp;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_any)
  );

  assign win_addr  = req_addr[int'(grant_idx)*AW +: AW];
  assign win_wdata = req_wdata[int'(grant_idx)*DW +: DW];

  // Decode of the latched address; out-of-range addresses decode to nothing.
  always_comb begin
    addr_hot = '0;
    q_sel    = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (cur_addr == AW'(r)) begin
        addr_hot[r] = 1'b1;
        q_sel       = bank_q[r*DW +: DW];
      end
    end
  end

  always_comb begin
    w_hot = '0;
    w_hot[cur_w] = 1'b1;
  end

  // Outputs are gated by rst so an aborted transaction can never leak a
  // load pulse or response in the cycle reset is asserted.
  assign in_exec_wr = !rst && (state == ST_EXEC) && cur_we && !cur_err;
  assign in_resp    = !rst && (state == ST_RESP);

  assign req_ready = (!rst && state == ST_IDLE) ? grant : '0;
  assign bank_ld   = in_exec_wr ? addr_hot  : '0;
  assign bank_d    = in_exec_wr ? cur_wdata : '0;
  assign rsp_valid = in_resp ? w_hot     : '0;
  assign rsp_rdata = in_resp ? cur_rdata : '0;
  assign rsp_err   = in_resp ? cur_err   : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= IW'(NREQ - 1);
      cur_w     <= '0;
      cur_we    <= 1'b0;
      cur_err   <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            cur_w     <= grant_idx;
            rr_ptr    <= grant_idx;
            cur_we    <= req_we[grant_idx];
            cur_addr  <= win_addr;
            cur_wdata <= win_wdata;
            cur_err   <= (int'(win_addr) >= NREGS);
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Writes echo their own data back; errors return zero.
          if (cur_err)     cur_rdata <= '0;
          else if (cur_we) cur_rdata <= cur_wdata;
          else             cur_rdata <= q_sel;
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter (NREQ=4, NREGS=6, AW=3).
// A timeline model predicts grants, load pulses and responses every cycle;
// directed scenarios add literal expectations on top.
module tb_regbank_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 6;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_we = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic [NREGS-1:0]     bank_ld;
  logic [DW-1:0]        bank_d;
  logic [NREGS*DW-1:0]  bank_q;

  int checks = 0;
  int errors = 0;

  regbank_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bank_ld   (bank_ld),
    .bank_d    (bank_d),
    .bank_q    (bank_q)
  );

  always #5 clk = ~clk;

  // Register bank environment (not reset by the arbiter's rst).
  logic [DW-1:0] bank_mem [NREGS] = '{default: '0};

  always @(posedge clk) begin
    for (int r = 0; r < NREGS; r++)
      if (bank_ld[r]) bank_mem[r] <= bank_d;
  end

  always_comb begin
    bank_q = '0;
    for (int r = 0; r < NREGS; r++) bank_q[r*DW +: DW] = bank_mem[r];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // Expectations are filed under the absolute cycle number they apply to.
  int cyc = 0;
  int next_ok = 0;
  int last = NREQ - 1;
  logic [DW-1:0]    mem_ref [NREGS] = '{default: '0};
  logic [NREGS-1:0] e_ld    [int];
  logic [DW-1:0]    e_d     [int];
  int               e_waddr [int];
  logic [NREQ-1:0]  e_rv    [int];
  logic [DW-1:0]    e_rd    [int];
  logic             e_err   [int];

  always @(negedge clk) begin : model
    logic [NREQ-1:0]  x_ready, x_rv, oh;
    logic [NREGS-1:0] x_ld, lh;
    logic [DW-1:0]    x_d, x_rd, wd, rdv;
    logic             x_err, we;
    int               w, c, ai;

    x_ready = '0;
    if (rst) begin
      e_ld.delete(); e_d.delete(); e_waddr.delete();
      e_rv.delete(); e_rd.delete(); e_err.delete();
      next_ok = cyc + 1;
      last = NREQ - 1;
    end else if (cyc >= next_ok && |req_valid) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (last + k) % NREQ;
        if (w < 0 && req_valid[c]) w = c;
      end
      x_ready[w] = 1'b1;
      last = w;
      next_ok = cyc + 3;
      ai = int'(req_addr[w*AW +: AW]);
      we = req_we[w];
      wd = req_wdata[w*DW +: DW];
      oh = '0; oh[w] = 1'b1;
      e_rv[cyc+2]  = oh;
      e_err[cyc+2] = (ai >= NREGS);
      if (ai >= NREGS) rdv = '0;
      else if (we)     rdv = wd;
      else             rdv = mem_ref[ai];
      e_rd[cyc+2] = rdv;
      if (we && ai < NREGS) begin
        lh = '0; lh[ai] = 1'b1;
        e_ld[cyc+1] = lh;
        e_d[cyc+1] = wd;
        e_waddr[cyc+1] = ai;
      end
    end

    x_ld  = e_ld.exists(cyc)  ? e_ld[cyc]  : '0;
    x_d   = e_d.exists(cyc)   ? e_d[cyc]   : '0;
    x_rv  = e_rv.exists(cyc)  ? e_rv[cyc]  : '0;
    x_rd  = e_rd.exists(cyc)  ? e_rd[cyc]  : '0;
    x_err = e_err.exists(cyc) ? e_err[cyc] : 1'b0;

    chk("m_req_ready", 32'(req_ready), 32'(x_ready));
    chk("m_bank_ld",   32'(bank_ld),   32'(x_ld));
    chk("m_bank_d",    32'(bank_d),    32'(x_d));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(x_rv));
    chk("m_rsp_rdata", 32'(rsp_rdata), 32'(x_rd));
    chk("m_rsp_err",   32'(rsp_err),   32'(x_err));

    if (e_ld.exists(cyc)) begin
      mem_ref[e_waddr[cyc]] = e_d[cyc];
      e_ld.delete(cyc); e_d.delete(cyc); e_waddr.delete(cyc);
    end
    if (e_rv.exists(cyc)) begin
      e_rv.delete(cyc); e_rd.delete(cyc); e_err.delete(cyc);
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Leaves the caller at the negedge of the accept cycle.
  task automatic wait_grant(input int who);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[who]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant_wait", 32'(ok), 32'(1'b1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic   found;
    int     idx, cnt3;
    longint prev_t;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",  32'(req_ready), 32'(4'b0000));
    chk("rst_rsp",    32'(rsp_valid), 32'(4'b0000));
    chk("rst_ld",     32'(bank_ld),   32'(6'b000000));
    chk("rst_rdata",  32'(rsp_rdata), 32'(16'h0000));
    tick();

    // Requester 1 writes 0xBEEF to reg 3.
    set_req(1, 1'b1, 1'b1, 3'd3, 16'hBEEF);
    wait_grant(1);
    chk("wr_ready", 32'(req_ready), 32'(4'b0010));
    tick();
    set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("wr_ld", 32'(bank_ld), 32'(6'b001000));
    chk("wr_d",  32'(bank_d),  32'(16'hBEEF));
    @(negedge clk);
    chk("wr_rsp",   32'(rsp_valid), 32'(4'b0010));
    chk("wr_rdata", 32'(rsp_rdata), 32'(16'hBEEF));
    chk("wr_err",   32'(rsp_err),   32'(1'b0));
    tick();

    // Requester 2 reads reg 3.
    set_req(2, 1'b1, 1'b0, 3'd3, 16'h0);
    wait_grant(2);
    chk("rd_ready", 32'(req_ready), 32'(4'b0100));
    chk("rd_ld0",   32'(bank_ld),   32'(6'b000000));
    tick();
    set_req(2, 1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("rd_ld1", 32'(bank_ld), 32'(6'b000000));
    @(negedge clk);
    chk("rd_rsp",   32'(rsp_valid), 32'(4'b0100));
    chk("rd_rdata", 32'(rsp_rdata), 32'(16'hBEEF));
    chk("rd_ld2",   32'(bank_ld),   32'(6'b000000));
    tick();

    // Requester 0 writes out-of-range address 7.
    set_req(0, 1'b1, 1'b1, 3'd7, 16'hCAFE);
    wait_grant(0);
    tick();
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("err_ld", 32'(bank_ld), 32'(6'b000000));
    @(negedge clk);
    chk("err_rsp",   32'(rsp_valid), 32'(4'b0001));
    chk("err_flag",  32'(rsp_err),   32'(1'b1));
    chk("err_rdata", 32'(rsp_rdata), 32'(16'h0000));
    tick();

    // Continuous contention from all four requesters after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(i), 16'h0);
    prev_t = 0;
    for (int n = 0; n < 8; n++) begin
      found = 1'b0;
      for (int t = 0; t < 30; t++) begin
        @(negedge clk);
        if (|req_ready) begin
          found = 1'b1;
          break;
        end
      end
      chk("rr_found", 32'(found), 32'(1'b1));
      idx = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
      chk("rr_order", 32'(idx), 32'(n % NREQ));
      if (n > 0) chk("rr_spacing", 32'(($time - prev_t) / 10), 32'(3));
      prev_t = $time;
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Reset during EXEC of a write to reg 5 (rr pointer sits at 2 then).
    set_req(2, 1'b1, 1'b1, 3'd5, 16'h1234);
    wait_grant(2);
    tick();
    set_req(2, 1'b0, 1'b0, 3'd0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ld", 32'(bank_ld), 32'(6'b000000));
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 3'd5, 16'h0);
    set_req(3, 1'b1, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    chk("abort_rsp",   32'(rsp_valid), 32'(4'b0000));
    chk("abort_grant", 32'(req_ready), 32'(4'b0010));
    chk("abort_reg5",  32'(bank_mem[5]), 32'(16'h0000));
    tick();
    set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
    set_req(3, 1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_rd5", 32'(rsp_rdata), 32'(16'h0000));
    repeat (2) tick();

    // Requester 3 withdraws while requester 0 is served.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 3'd2, 16'h5555);
    set_req(3, 1'b1, 1'b0, 3'd4, 16'h0);
    wait_grant(0);
    chk("drop_ready", 32'(req_ready), 32'(4'b0001));
    tick();
    set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
    set_req(3, 1'b0, 1'b0, 3'd0, 16'h0);
    cnt3 = 0;
    @(negedge clk);
    chk("drop_ld", 32'(bank_ld), 32'(6'b000100));
    @(negedge clk);
    chk("drop_rsp",   32'(rsp_valid), 32'(4'b0001));
    chk("drop_rdata", 32'(rsp_rdata), 32'(16'h5555));
    repeat (8) begin
      @(negedge clk);
      if (req_ready[3]) cnt3++;
    end
    chk("drop_never_granted", 32'(cnt3), 32'(0));
    tick();

    // Requester 3 reads back reg 2.
    set_req(3, 1'b1, 1'b0, 3'd2, 16'h0);
    wait_grant(3);
    tick();
    set_req(3, 1'b0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("raw_rsp",   32'(rsp_valid), 32'(4'b1000));
    chk("raw_rdata", 32'(rsp_rdata), 32'(16'h5555));
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
